quad_decoder_bank: RTL and testbench



---
 rtl/quad_decoder_bank.sv | 143 ++++++++++++++
 tb/tb_quad_decoder_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_bank.sv
// Multi-channel quadrature encoder front end: sync, glitch filter, x4 decode,
// wrapping position, direction, sticky illegal flag and windowed velocity.
module quad_decoder_bank #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned POS_W  = 16,
  parameter int unsigned VEL_W  = 12,
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned FILT   = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NCH-1:0]         A,
  input  logic [NCH-1:0]         B,
  input  logic [NCH-1:0]         pos_clr,
  input  logic                   err_clr,
  output logic [NCH*POS_W-1:0]   pos,
  output logic [NCH*VEL_W-1:0]   vel,
  output logic                   vel_valid,
  output logic [NCH-1:0]         dir,
  output logic [NCH-1:0]         err
);

  localparam int unsigned STAB_W  = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned TMR_W   = $clog2(WINDOW);
  localparam int unsigned ARM_CYC = 3;

  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  // Next {A,B} state in the forward rotation 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0]       arm_cnt;
  logic             armed;
  logic [TMR_W-1:0] timer;
  logic             win_end;

  assign armed   = (arm_cnt == 2'(ARM_CYC));
  assign win_end = (timer == TMR_W'(WINDOW - 1));

  // Shared arming counter and velocity window timer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      arm_cnt   <= '0;
      timer     <= '0;
      vel_valid <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      timer     <= win_end ? '0 : timer + TMR_W'(1);
      vel_valid <= win_end;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]              s1, s2, filt, filt_n;
    logic [1:0][STAB_W-1:0]  stab, stab_n;
    logic                    fwd, rev, bad;
    logic signed [1:0]       step;
    logic [POS_W-1:0]        pos_q;
    logic                    dir_q, err_q;
    logic signed [VEL_W-1:0] acc, acc_n, sum_sat, vel_q;
    logic signed [VEL_W:0]   sum;
    logic                    sat_q, ovf;

    // Per-bit stability filter; bypassed while the bank is still arming.
    always_comb begin
      filt_n = filt;
      stab_n = '0;
      for (int b = 0; b < 2; b++) begin
        if (!armed) begin
          filt_n[b] = s2[b];
        end else if (s2[b] != filt[b]) begin
          if (stab[b] == STAB_W'(FILT - 1)) filt_n[b] = s2[b];
          else                              stab_n[b] = stab[b] + STAB_W'(1);
        end
      end
    end

    always_comb begin
      fwd  = armed && (filt_n == gray_next(filt));
      rev  = armed && (filt == gray_next(filt_n));
      bad  = armed && (filt_n == ~filt);
      step = fwd ? 2'sd1 : (rev ? -2'sd1 : 2'sd0);
    end

    // Saturating accumulator; once clamped it holds until the window closes.
    always_comb begin
      sum = {acc[VEL_W-1], acc} + {{(VEL_W-1){step[1]}}, step};
      ovf = (sum[VEL_W] != sum[VEL_W-1]);
      if (!ovf)          sum_sat = sum[VEL_W-1:0];
      else if (sum[VEL_W]) sum_sat = VEL_MIN;
      else               sum_sat = VEL_MAX;
      acc_n = sat_q ? acc : sum_sat;
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        s1    <= '0;
        s2    <= '0;
        filt  <= '0;
        stab  <= '0;
        pos_q <= '0;
        dir_q <= 1'b0;
        err_q <= 1'b0;
        acc   <= '0;
        sat_q <= 1'b0;
        vel_q <= '0;
      end else begin
        s1   <= {A[i], B[i]};
        s2   <= s1;
        filt <= filt_n;
        stab <= stab_n;
        if (pos_clr[i])  pos_q <= '0;
        else if (fwd)    pos_q <= pos_q + POS_W'(1);
        else if (rev)    pos_q <= pos_q - POS_W'(1);
        if (fwd)         dir_q <= 1'b1;
        else if (rev)    dir_q <= 1'b0;
        err_q <= bad | (err_q & ~err_clr);
        if (win_end) begin
          vel_q <= acc_n;
          acc   <= '0;
          sat_q <= 1'b0;
        end else begin
          acc   <= acc_n;
          sat_q <= sat_q | ovf;
        end
      end
    end

    assign pos[i*POS_W +: POS_W] = pos_q;
    assign vel[i*VEL_W +: VEL_W] = vel_q;
    assign dir[i]                = dir_q;
    assign err[i]                = err_q;
  end

endmodule

// File: tb/tb_quad_decoder_bank.sv
// Scoreboard bench for quad_decoder_bank: behavioural model predicts each cycle,
// monitor compares on the opposite clock edge and pops velocity on vel_valid.
module tb_quad_decoder_bank;

  localparam int unsigned NCH    = 2;
  localparam int unsigned POS_W  = 4;
  localparam int unsigned VEL_W  = 4;
  localparam int unsigned WINDOW = 100;
  localparam int unsigned FILT   = 2;
  localparam int VMAX = (1 << (VEL_W - 1)) - 1;
  localparam int VMIN = -(1 << (VEL_W - 1));

  logic                 CLK;
  logic                 reset;
  logic [NCH-1:0]       A, B, pos_clr;
  logic                 err_clr;
  logic [NCH*POS_W-1:0] pos;
  logic [NCH*VEL_W-1:0] vel;
  logic                 vel_valid;
  logic [NCH-1:0]       dir, err;

  quad_decoder_bank #(
    .NCH(NCH), .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW(WINDOW), .FILT(FILT)
  ) dut (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .pos_clr(pos_clr), .err_clr(err_clr),
    .pos(pos), .vel(vel), .vel_valid(vel_valid), .dir(dir), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [NCH*POS_W-1:0] pos;
    logic [NCH-1:0]       dir;
    logic [NCH-1:0]       err;
    logic                 vv;
    logic                 rst;
  } exp_t;

  exp_t                 exp_q[$];
  logic [NCH*VEL_W-1:0] vel_exp_q[$];
  int errors = 0;
  int checks = 0;
  int vel_seen = 0;

  // Quadrature rotation order; position in this list gives the phase.
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int phase(input logic [1:0] v);
    for (int k = 0; k < 4; k++) if (seq[k] == v) return k;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model state.
  logic [1:0] m_s1 [NCH];
  logic [1:0] m_s2 [NCH];
  logic [1:0] m_filt [NCH];
  int         m_run [NCH][2];
  int         m_pos [NCH];
  logic       m_dir [NCH];
  logic       m_err [NCH];
  int         m_acc [NCH];
  logic       m_sat [NCH];
  int         m_edges;

  initial begin : model
    exp_t e;
    logic [NCH*VEL_W-1:0] vw;
    logic [1:0] nw;
    logic armed, win_end, ill;
    int d, delta, t;
    forever begin
      @(posedge CLK);
      e.vv  = 1'b0;
      e.rst = reset;
      vw    = '0;
      if (reset) begin
        m_edges = 0;
        for (int c = 0; c < NCH; c++) begin
          m_s1[c] = '0; m_s2[c] = '0; m_filt[c] = '0;
          m_run[c][0] = 0; m_run[c][1] = 0;
          m_pos[c] = 0; m_dir[c] = 1'b0; m_err[c] = 1'b0;
          m_acc[c] = 0; m_sat[c] = 1'b0;
        end
      end else begin
        armed   = (m_edges >= 3);
        win_end = ((m_edges % WINDOW) == WINDOW - 1);
        for (int c = 0; c < NCH; c++) begin
          nw = m_filt[c];
          for (int b = 0; b < 2; b++) begin
            if (!armed) begin
              nw[b] = m_s2[c][b];
              m_run[c][b] = 0;
            end else if (m_s2[c][b] != m_filt[c][b]) begin
              m_run[c][b]++;
              if (m_run[c][b] == FILT) begin
                nw[b] = m_s2[c][b];
                m_run[c][b] = 0;
              end
            end else begin
              m_run[c][b] = 0;
            end
          end
          d = 0;
          ill = 1'b0;
          if (armed && nw != m_filt[c]) begin
            delta = (phase(nw) - phase(m_filt[c]) + 4) % 4;
            if (delta == 1)      begin d = 1;  m_dir[c] = 1'b1; end
            else if (delta == 3) begin d = -1; m_dir[c] = 1'b0; end
            else                 ill = 1'b1;
          end
          m_err[c] = ill | (m_err[c] & ~err_clr);
          if (pos_clr[c]) m_pos[c] = 0;
          else            m_pos[c] = (m_pos[c] + d + (1 << POS_W)) % (1 << POS_W);
          if (!m_sat[c]) begin
            t = m_acc[c] + d;
            if (t > VMAX) begin t = VMAX; m_sat[c] = 1'b1; end
            if (t < VMIN) begin t = VMIN; m_sat[c] = 1'b1; end
            m_acc[c] = t;
          end
          if (win_end) begin
            vw[c*VEL_W +: VEL_W] = VEL_W'(m_acc[c]);
            m_acc[c] = 0;
            m_sat[c] = 1'b0;
          end
          m_filt[c] = nw;
          m_s2[c]   = m_s1[c];
          m_s1[c]   = {A[c], B[c]};
        end
        if (win_end) begin
          e.vv = 1'b1;
          vel_exp_q.push_back(vw);
        end
        m_edges++;
      end
      for (int c = 0; c < NCH; c++) begin
        e.pos[c*POS_W +: POS_W] = POS_W'(m_pos[c]);
        e.dir[c] = m_dir[c];
        e.err[c] = m_err[c];
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    logic [NCH*VEL_W-1:0] ve;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pos", 64'(pos), 64'(e.pos));
        chk("dir", 64'(dir), 64'(e.dir));
        chk("err", 64'(err), 64'(e.err));
        chk("vel_valid", 64'(vel_valid), 64'(e.vv));
        if (e.rst) chk("vel_reset", 64'(vel), 64'(0));
        if (vel_valid) begin
          if (vel_exp_q.size() == 0) begin
            chk("vel_unexpected", 64'(1), 64'(0));
          end else begin
            ve = vel_exp_q.pop_front();
            chk("vel", 64'(vel), 64'(ve));
            vel_seen++;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic move(input int ch, input bit fwd, input int hold);
    int p;
    p = phase({A[ch], B[ch]});
    p = fwd ? (p + 1) % 4 : (p + 3) % 4;
    A[ch] = seq[p][1];
    B[ch] = seq[p][0];
    wait_cyc(hold);
  endtask

  initial begin : stimulus
    reset   = 1'b1;
    A       = '0;
    B       = '0;
    A[1]    = 1'b1;
    B[1]    = 1'b1;
    pos_clr = '0;
    err_clr = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);

    for (int k = 0; k < 4; k++) move(0, 1'b1, 10);

    for (int w = 1; w <= 3; w++) begin
      A[0] = ~A[0];
      wait_cyc(w);
      A[0] = ~A[0];
      wait_cyc(10);
    end

    for (int k = 0; k < 9; k++) move(0, 1'b0, 6);
    for (int k = 0; k < 9; k++) move(0, 1'b1, 6);

    // Illegal double toggle, then one coinciding with err_clr, then a lone clear.
    A[0] = ~A[0]; B[0] = ~B[0];
    wait_cyc(12);
    A[0] = ~A[0]; B[0] = ~B[0];
    wait_cyc(3);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(5);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(5);

    // pos_clr landing on the same edge as a step.
    move(0, 1'b1, 3);
    pos_clr[0] = 1'b1;
    wait_cyc(1);
    pos_clr[0] = 1'b0;
    wait_cyc(8);

    for (int k = 0; k < 5; k++)  move(0, 1'b1, 4);
    wait_cyc(100);
    for (int k = 0; k < 20; k++) begin
      move(0, 1'b1, 2);
      move(1, 1'b0, 2);
    end
    wait_cyc(220);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 6)       A[c] = ~A[c];
        else if (r < 12) B[c] = ~B[c];
        else if (r < 13) begin A[c] = ~A[c]; B[c] = ~B[c]; end
        pos_clr[c] = ($urandom_range(0, 99) == 0);
      end
      err_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
      end
      wait_cyc(1);
    end
    pos_clr = '0;
    err_clr = 1'b0;
    wait_cyc(10);

    if (vel_seen == 0) chk("vel_pulses_seen", 64'(0), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
